// File: rtl/coherence_pkg.sv
// rtl/coherence_pkg.sv - shared encodings for the MSI snooping-bus controller
package coherence_pkg;

    typedef enum logic [1:0] {
        OP_READ_MISS  = 2'b00,
        OP_WRITE_MISS = 2'b01,
        OP_INVALIDATE = 2'b10,
        OP_WRITE_BACK = 2'b11
    } bus_op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BCAST  = 3'd1,
        ST_SNOOP  = 3'd2,
        ST_MEM_WB = 3'd3,
        ST_MEM_RD = 3'd4,
        ST_DONE   = 3'd5
    } bus_state_e;

    // Block states shared with the per-cache sm_cpu / sm_bus machines
    typedef enum logic [1:0] {
        INVALID  = 2'b00,
        SHARED   = 2'b01,
        MODIFIED = 2'b10
    } msi_state_e;

    // True when more than one bit of a (up to 8-bit) vector is set
    function automatic logic multi_hot(input logic [7:0] v);
        return (v & (v - 8'd1)) != 8'd0;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin picker over N requesters with registered pointer
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    logic [IDX_W-1:0] ptr_q;

    // Search downward in distance so the requester closest after ptr_q wins last
    always_comb begin
        int j;
        grant_idx = '0;
        any       = 1'b0;
        for (int k = N; k >= 1; k--) begin
            j = int'(ptr_q) + k;
            if (j >= N) j = j - N;
            if (req[j[IDX_W-1:0]]) begin
                grant_idx = j[IDX_W-1:0];
                any       = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= IDX_W'(N - 1);
        end else if (advance && any) begin
            ptr_q <= grant_idx;
        end
    end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// rtl/coherence_bus_ctrl.sv - MSI snooping-bus arbiter, broadcaster and memory sequencer
module coherence_bus_ctrl
    import coherence_pkg::*;
#(
    parameter int NUM_PROC = 4,
    parameter int ADDR_W   = 3
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_PROC-1:0]        req,
    input  logic [2*NUM_PROC-1:0]      req_op,
    input  logic [ADDR_W*NUM_PROC-1:0] req_addr,
    output logic [NUM_PROC-1:0]        grant,
    output logic [NUM_PROC-1:0]        done,
    output logic                       snoop_valid,
    output logic [1:0]                 snoop_op,
    output logic [ADDR_W-1:0]          snoop_addr,
    output logic [NUM_PROC-1:0]        snoop_src,
    input  logic [NUM_PROC-1:0]        snoop_wb,
    input  logic [NUM_PROC-1:0]        snoop_abort,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    input  logic                       mem_ack,
    output logic [2:0]                 state,
    output logic                       protocol_err
);

    localparam int IDX_W = $clog2(NUM_PROC);

    bus_state_e              state_q, state_d;
    bus_op_e                 op_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [NUM_PROC-1:0]     src_q;
    logic                    err_q;

    logic [IDX_W-1:0]        win_idx;
    logic                    win_any;
    logic                    start;
    logic [1:0]              sel_op;
    logic [ADDR_W-1:0]       sel_addr;
    logic [NUM_PROC-1:0]     sel_oh;
    logic [NUM_PROC-1:0]     masked_abort;
    logic [NUM_PROC-1:0]     masked_wb;

    assign start = (state_q == ST_IDLE) && win_any;

    rr_arbiter #(.N(NUM_PROC)) u_arb (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .advance   (start),
        .grant_idx (win_idx),
        .any       (win_any)
    );

    always_comb begin
        sel_op   = '0;
        sel_addr = '0;
        sel_oh   = '0;
        for (int i = 0; i < NUM_PROC; i++) begin
            if (win_idx == IDX_W'(i)) begin
                sel_op    = req_op[2*i +: 2];
                sel_addr  = req_addr[ADDR_W*i +: ADDR_W];
                sel_oh[i] = 1'b1;
            end
        end
    end

    // The requester's own responses are never meaningful to its own transaction
    assign masked_abort = snoop_abort & ~src_q;
    assign masked_wb    = snoop_wb & ~src_q;

    always_comb begin
        state_d     = state_q;
        grant       = '0;
        done        = '0;
        snoop_valid = 1'b0;
        snoop_op    = '0;
        snoop_addr  = '0;
        snoop_src   = '0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;

        if (state_q != ST_IDLE) grant = src_q;

        case (state_q)
            ST_IDLE: begin
                if (win_any)
                    state_d = (bus_op_e'(sel_op) == OP_WRITE_BACK) ? ST_MEM_RD : ST_BCAST;
            end
            ST_BCAST: begin
                snoop_valid = 1'b1;
                snoop_op    = op_q;
                snoop_addr  = addr_q;
                snoop_src   = src_q;
                state_d     = ST_SNOOP;
            end
            ST_SNOOP: begin
                if (op_q == OP_INVALIDATE)
                    state_d = ST_DONE;
                else if ((|masked_abort) || (|masked_wb))
                    state_d = ST_MEM_WB;
                else
                    state_d = ST_MEM_RD;
            end
            ST_MEM_WB: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = addr_q;
                if (mem_ack) state_d = ST_MEM_RD;
            end
            ST_MEM_RD: begin
                mem_req  = 1'b1;
                mem_we   = (op_q == OP_WRITE_BACK);
                mem_addr = addr_q;
                if (mem_ack) state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = src_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_READ_MISS;
            addr_q  <= '0;
            src_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start) begin
                op_q   <= bus_op_e'(sel_op);
                addr_q <= sel_addr;
                src_q  <= sel_oh;
            end
            if (state_q == ST_SNOOP && multi_hot(8'(masked_abort)))
                err_q <= 1'b1;
        end
    end

    assign state        = state_q;
    assign protocol_err = err_q;

endmodule

// File: doc/coherence_bus_ctrl.md
Name: coherence_bus_ctrl

Overview:
Snooping-bus controller for the MSI coherence system. It sits between the per-cache CPU-side state machines (sm_cpu) and the snoop-side state machines (sm_bus) plus memory. It arbitrates bus requests (read miss, write miss, invalidate, write-back) from NUM_PROC caches round-robin. It broadcasts the winning request to all other caches, collects their write-back/abort responses, sequences the memory access, and pulses completion back to the requester.

Parameters:
NUM_PROC, 4, number of attached caches/requesters (2..8)
ADDR_W, 3, block address width

Ports:
clock  in  1  single system clock, all state changes on rising edge
reset  in  1  synchronous, active-high reset
req  in  NUM_PROC  per-cache bus request; held until matching done bit
req_op  in  2*NUM_PROC  per-cache op, slice i = [2i+1:2i]; 00 READ_MISS, 01 WRITE_MISS, 10 INVALIDATE, 11 WRITE_BACK
req_addr  in  ADDR_W*NUM_PROC  per-cache block address, slice i
grant  out  NUM_PROC  one-hot owner of current transaction
done  out  NUM_PROC  one-cycle one-hot completion pulse
snoop_valid  out  1  broadcast strobe, one cycle per transaction
snoop_op  out  2  broadcast op
snoop_addr  out  ADDR_W  broadcast address
snoop_src  out  NUM_PROC  one-hot source; snoopers ignore the broadcast if their bit is set
snoop_wb  in  NUM_PROC  snooper held block Modified and is writing back (writeBack_bus)
snoop_abort  in  NUM_PROC  snooper requests memory access abort (abortMemoryAccess_bus)
mem_req  out  1  memory access request, held until mem_ack
mem_we  out  1  1 = write, 0 = read; valid with mem_req
mem_addr  out  ADDR_W  memory address; valid with mem_req
mem_ack  in  1  memory completion, sampled only while mem_req=1
state  out  3  current FSM state encoding, for LED debug
protocol_err  out  1  sticky error flag

Behaviour:
- Reset:
  - All outputs 0; FSM IDLE.
  - Round-robin pointer set to NUM_PROC-1, so cache 0 has first priority.
  - protocol_err cleared.
  - Reset mid-transaction aborts it silently, with no done pulse; mem_req drops the next cycle.
- FSM states (encoding in package): IDLE=0, BCAST=1, SNOOP=2, MEM_WB=3, MEM_RD=4, DONE=5.
- IDLE:
  - If any req, the winner is the first set bit searching upward from pointer+1, with wrap-around.
  - Latch op, addr and index of the winner; pointer <= winner.
  - Next state is MEM_RD with mem_we=1 if op==WRITE_BACK (no broadcast), else BCAST.
  - grant is registered: asserted from the cycle after selection through DONE inclusive.
- BCAST: one cycle; snoop_valid=1; snoop_op, snoop_addr and snoop_src carry the latched values. Next state SNOOP.
- SNOOP (one cycle):
  - Sample snoop_wb and snoop_abort masked by ~src.
  - More than one masked abort bit sets protocol_err.
  - INVALIDATE goes to DONE, with no memory access, regardless of responses.
  - Otherwise any masked abort or wb goes to MEM_WB; else MEM_RD.
- MEM_WB:
  - mem_req=1, mem_we=1, mem_addr=latched addr.
  - On mem_ack go to MEM_RD.
- MEM_RD:
  - mem_req=1, mem_addr=latched addr; mem_we=1 for an own WRITE_BACK, else 0.
  - On mem_ack go to DONE.
  - mem_req stays asserted for as long as mem_ack is low; there is no timeout.
- DONE: done[src]=1 for exactly one cycle; grant drops the next cycle; next state IDLE.
- Minimum latency (READ_MISS, no abort, mem_ack in the first mem_req cycle):
  - req sampled cycle 0; grant/snoop_valid cycle 1; SNOOP cycle 2; mem_req cycle 3; done cycle 4.
  - A new grant can come earliest in cycle 6.
- Requester rules:
  - Dropping req mid-transaction is ignored; the transaction completes and done still pulses.
  - req/op/addr changes after the IDLE sample are ignored.
- Snoop inputs outside SNOOP and mem_ack outside the MEM states are ignored.

Decomposition:
- coherence_pkg holds:
  - op encodings OP_READ_MISS/OP_WRITE_MISS/OP_INVALIDATE/OP_WRITE_BACK;
  - bus FSM state encodings;
  - MSI block-state encodings (INVALID=2'b00, SHARED=2'b01, MODIFIED=2'b10), shared with sm_cpu/sm_bus.
- Sub-module rr_arbiter(clock, reset, req, advance, grant_idx, any): combinational pick from a registered pointer, updated on advance.

Test Plan:
- Cache 1 READ_MISS addr 3'b101, no snoop responses, mem_ack on first mem_req cycle -> grant=0010 in cycle 1; snoop_valid=1 with snoop_op=00, snoop_addr=101, snoop_src=0010; mem_req=1, we=0, addr=101 in cycle 3; done=0010 in cycle 4.
- Cache 0 WRITE_MISS addr 3'b010, snoop_abort=0100 and snoop_wb=0100 in SNOOP -> MEM_WB write to 010, then MEM_RD read of 010; done=0001; protocol_err=0.
- req=1111 held continuously -> grants in order 0001, 0010, 0100, 1000, 0001; cache 0 wins the first grant after reset.
- Cache 2 INVALIDATE addr 3'b111 -> single snoop_valid cycle, mem_req never asserted, done=0100 two cycles after the broadcast.
- Cache 3 WRITE_BACK addr 3'b001 -> snoop_valid never asserted; mem_req=1 with we=1, addr=001; mem_ack delayed 5 cycles keeps mem_req high; then done=1000.
- Masked snoop_abort=0011 (src=0100) -> protocol_err=1 and stays set; reset asserted during MEM_RD -> all outputs 0 and no done pulse.
